// File: rtl/crc32_ieee8023_if.sv
// Byte-strobe bus for the IEEE 802.3 FCS generator/checker.
// The producer side drives the byte and controls, and the CRC block returns the running register and FCS byte.
interface crc32_ieee8023_if;
  logic [7:0]  d;
  logic        load_init;
  logic        calc;
  logic        d_valid;
  logic [31:0] crc_reg;
  logic [7:0]  crc;

  modport master (
    output d, load_init, calc, d_valid,
    input  crc_reg, crc
  );

  modport slave (
    input  d, load_init, calc, d_valid,
    output crc_reg, crc
  );
endinterface

// File: rtl/crc32_ieee8023.sv
// Byte-wide IEEE 802.3 CRC-32 (FCS) generator/checker: absorbs frame bytes, then shifts
// the four FCS bytes out in wire order. crc_reg is the raw register (not inverted, not reflected).
module crc32_ieee8023 (
  input  logic                   clk,
  input  logic                   rstn,
  crc32_ieee8023_if.slave        bus
);

  localparam logic [31:0] POLY = 32'h04C1_1DB7;
  localparam logic [31:0] INIT = 32'hFFFF_FFFF;

  logic [31:0] crc_reg_q;
  logic [31:0] crc_reg_d;
  logic [7:0]  crc_byte;

  // Eight serial LFSR steps unrolled into one XOR network, d[0] entering first.
  function automatic logic [31:0] next_crc(input logic [31:0] c, input logic [7:0] data);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int unsigned i = 0; i < 8; i++) begin
      fb = r[31] ^ data[i];
      r  = {r[30:0], 1'b0} ^ (fb ? POLY : '0);
    end
    return r;
  endfunction

  always_comb begin
    crc_reg_d = crc_reg_q;
    if (bus.load_init) begin
      crc_reg_d = INIT;
    end else if (bus.d_valid) begin
      if (bus.calc) begin
        crc_reg_d = next_crc(crc_reg_q, bus.d);
      end else begin
        crc_reg_d = {crc_reg_q[23:0], 8'hFF};
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      crc_reg_q <= INIT;
    end else begin
      crc_reg_q <= crc_reg_d;
    end
  end

  // Top byte bit-reversed and inverted, so crc[0] is the first FCS bit on the wire.
  always_comb begin
    crc_byte = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      crc_byte[i] = ~crc_reg_q[31 - i];
    end
  end

  assign bus.crc_reg = crc_reg_q;
  assign bus.crc     = crc_byte;

endmodule

// File: tb/tb_crc32_ieee8023.sv
// Self-checking bench for crc32_ieee8023: a serial reference LFSR predicts every register
// update; predictions are queued per strobe and compared once the DUT clock edge has passed.
module tb_crc32_ieee8023;

  logic clk    = 1'b0;
  logic clk_en = 1'b0;
  logic rstn   = 1'b1;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_reg;
  logic [31:0] exp_q[$];

  crc32_ieee8023_if ifc();

  crc32_ieee8023 dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (ifc)
  );

  initial begin
    forever begin
      #5;
      if (clk_en) clk = ~clk;
    end
  end

  function automatic logic [31:0] ref_next(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int k = 0; k < 8; k++) begin
      if (r[31] ^ b[k]) r = (r << 1) ^ 32'h04C11DB7;
      else              r = r << 1;
    end
    return r;
  endfunction

  function automatic logic [7:0] ref_fcs(input logic [31:0] r);
    logic [7:0] f;
    for (int k = 0; k < 8; k++) f[k] = ~r[31 - k];
    return f;
  endfunction

  // Drive one cycle of inputs at the falling edge, predict the register, push it, step past the rising edge.
  task automatic drive_cycle(input logic [7:0] b, input logic c, input logic v, input logic li);
    @(negedge clk);
    ifc.d         = b;
    ifc.calc      = c;
    ifc.d_valid   = v;
    ifc.load_init = li;
    if (li)          m_reg = 32'hFFFFFFFF;
    else if (v && c) m_reg = ref_next(m_reg, b);
    else if (v)      m_reg = {m_reg[23:0], 8'hFF};
    exp_q.push_back(m_reg);
    @(posedge clk);
    #1;
    ifc.d_valid   = 1'b0;
    ifc.load_init = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] e;
    rstn = 1'b0;
    #1;
    m_reg = 32'hFFFFFFFF;
    checks++;
    if (ifc.crc_reg !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL reset_reg: got %h expected ffffffff", ifc.crc_reg);
    end
    checks++;
    if (ifc.crc !== 8'h00) begin
      errors++;
      $display("FAIL reset_crc: got %h expected 00", ifc.crc);
    end
    #3;
    rstn   = 1'b1;
    clk_en = 1'b1;
    drive_cycle(8'h55, 1'b1, 1'b1, 1'b0);
    e = exp_q.pop_front();
    checks++;
    if (ifc.crc_reg !== e) begin
      errors++;
      $display("FAIL first_update: got %h expected %h", ifc.crc_reg, e);
    end
  endtask

  task automatic test_check_vector;
    logic [31:0] e;
    logic [7:0]  fcs_exp [4];
    fcs_exp = '{8'h26, 8'h39, 8'hF4, 8'hCB};
    drive_cycle(8'h00, 1'b1, 1'b0, 1'b1);
    e = exp_q.pop_front();
    checks++;
    if (ifc.crc_reg !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL cv_init: got %h expected ffffffff", ifc.crc_reg);
    end
    for (int i = 0; i < 9; i++) begin
      drive_cycle(8'h31 + 8'(i), 1'b1, 1'b1, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (ifc.crc_reg !== e) begin
        errors++;
        $display("FAIL cv_byte%0d: got %h expected %h", i, ifc.crc_reg, e);
      end
    end
    checks++;
    if (ifc.crc_reg !== 32'h9B63D02C) begin
      errors++;
      $display("FAIL cv_reg: got %h expected 9b63d02c", ifc.crc_reg);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ifc.crc !== fcs_exp[i]) begin
        errors++;
        $display("FAIL cv_fcs%0d: got %h expected %h", i, ifc.crc, fcs_exp[i]);
      end
      drive_cycle(8'hA5, 1'b0, 1'b1, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (ifc.crc_reg !== e) begin
        errors++;
        $display("FAIL cv_shift%0d: got %h expected %h", i, ifc.crc_reg, e);
      end
    end
    checks++;
    if (ifc.crc_reg !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL cv_after_shift: got %h expected ffffffff", ifc.crc_reg);
    end
  endtask

  task automatic test_residue(input logic bad);
    logic [31:0] e;
    logic [7:0]  fcs [4];
    fcs = '{8'h26, 8'h39, 8'hF4, 8'hCB};
    if (bad) fcs[3] = 8'h34;
    drive_cycle(8'h00, 1'b0, 1'b0, 1'b1);
    e = exp_q.pop_front();
    for (int i = 0; i < 13; i++) begin
      drive_cycle((i < 9) ? 8'h31 + 8'(i) : fcs[i - 9], 1'b1, 1'b1, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (ifc.crc_reg !== e) begin
        errors++;
        $display("FAIL res_byte%0d bad=%0d: got %h expected %h", i, bad, ifc.crc_reg, e);
      end
    end
    checks++;
    if (!bad && ifc.crc_reg !== 32'hC704DD7B) begin
      errors++;
      $display("FAIL residue_good: got %h expected c704dd7b", ifc.crc_reg);
    end else if (bad && ifc.crc_reg === 32'hC704DD7B) begin
      errors++;
      $display("FAIL residue_bad: got %h expected not c704dd7b", ifc.crc_reg);
    end
  endtask

  task automatic test_gating;
    logic [31:0] e;
    logic [31:0] snap;
    drive_cycle(8'h00, 1'b0, 1'b0, 1'b1);
    e = exp_q.pop_front();
    drive_cycle(8'h3C, 1'b1, 1'b1, 1'b0);
    e = exp_q.pop_front();
    snap = m_reg;
    for (int i = 0; i < 10; i++) begin
      drive_cycle(8'($urandom), 1'(i), 1'b0, 1'b0);
      e = exp_q.pop_front();
    end
    checks++;
    if (ifc.crc_reg !== snap) begin
      errors++;
      $display("FAIL gating_hold: got %h expected %h", ifc.crc_reg, snap);
    end
    drive_cycle(8'h77, 1'b1, 1'b1, 1'b1);
    e = exp_q.pop_front();
    checks++;
    if (ifc.crc_reg !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL load_priority_calc: got %h expected ffffffff", ifc.crc_reg);
    end
    drive_cycle(8'h12, 1'b1, 1'b1, 1'b0);
    e = exp_q.pop_front();
    drive_cycle(8'h77, 1'b0, 1'b1, 1'b1);
    e = exp_q.pop_front();
    checks++;
    if (ifc.crc_reg !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL load_priority_shift: got %h expected ffffffff", ifc.crc_reg);
    end
  endtask

  task automatic run_frame(input logic [7:0] frame [104], input int n, input string tag);
    logic [31:0] e;
    drive_cycle(8'h00, 1'b0, 1'b0, 1'b1);
    e = exp_q.pop_front();
    for (int i = 0; i < n; i++) begin
      drive_cycle(frame[i], 1'b1, 1'b1, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (ifc.crc_reg !== e) begin
        errors++;
        $display("FAIL %s_byte%0d: got %h expected %h", tag, i, ifc.crc_reg, e);
      end
      drive_cycle(8'($urandom), 1'($urandom), 1'b0, 1'b0);
      e = exp_q.pop_front();
    end
  endtask

  task automatic test_ethernet_frame;
    logic [7:0]  frame [104];
    logic [7:0]  fcs_m;
    logic [31:0] e;
    for (int i = 0; i < 6; i++) frame[i] = 8'hFF;
    for (int i = 0; i < 6; i++) frame[6 + i] = 8'hE0 + 8'(i);
    frame[12] = 8'h08;
    frame[13] = 8'h06;
    for (int i = 14; i < 100; i++) frame[i] = 8'($urandom);
    run_frame(frame, 100, "gen");
    for (int i = 0; i < 4; i++) begin
      fcs_m = ref_fcs(m_reg);
      frame[100 + i] = fcs_m;
      checks++;
      if (ifc.crc !== fcs_m) begin
        errors++;
        $display("FAIL eth_fcs%0d: got %h expected %h", i, ifc.crc, fcs_m);
      end
      drive_cycle(8'h00, 1'b0, 1'b1, 1'b0);
      e = exp_q.pop_front();
      drive_cycle(8'h00, 1'b1, 1'b0, 1'b0);
      e = exp_q.pop_front();
    end
    checks++;
    if (ifc.crc_reg !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL eth_after_shift: got %h expected ffffffff", ifc.crc_reg);
    end
    run_frame(frame, 104, "chk");
    checks++;
    if (ifc.crc_reg !== 32'hC704DD7B) begin
      errors++;
      $display("FAIL eth_residue: got %h expected c704dd7b", ifc.crc_reg);
    end
    for (int i = 100; i < 104; i++) frame[i] = ~frame[i];
    run_frame(frame, 104, "inv");
    checks++;
    if (ifc.crc_reg === 32'hC704DD7B) begin
      errors++;
      $display("FAIL eth_inverted_fcs: got %h expected not c704dd7b", ifc.crc_reg);
    end
  endtask

  task automatic test_reset_midframe;
    logic [31:0] e;
    drive_cycle(8'h00, 1'b0, 1'b0, 1'b1);
    e = exp_q.pop_front();
    for (int i = 0; i < 3; i++) begin
      drive_cycle(8'hC0 + 8'(i), 1'b1, 1'b1, 1'b0);
      e = exp_q.pop_front();
    end
    @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    m_reg = 32'hFFFFFFFF;
    checks++;
    if (ifc.crc_reg !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL midreset_reg: got %h expected ffffffff", ifc.crc_reg);
    end
    checks++;
    if (ifc.crc !== 8'h00) begin
      errors++;
      $display("FAIL midreset_crc: got %h expected 00", ifc.crc);
    end
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    drive_cycle(8'h9A, 1'b1, 1'b1, 1'b0);
    e = exp_q.pop_front();
    checks++;
    if (ifc.crc_reg !== e) begin
      errors++;
      $display("FAIL midreset_resume: got %h expected %h", ifc.crc_reg, e);
    end
  endtask

  initial begin
    ifc.d         = 8'h00;
    ifc.calc      = 1'b0;
    ifc.d_valid   = 1'b0;
    ifc.load_init = 1'b0;
    m_reg         = 32'hFFFFFFFF;
    #2;
    test_reset();
    test_check_vector();
    test_residue(1'b0);
    test_residue(1'b1);
    test_gating();
    test_ethernet_frame();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
